// File: rtl/sw_pkg.sv
// Shared timing constants for the slide-switch front end.
package sw_pkg;
    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 20;
    localparam int SW_CNT_MAX  = CLK_HZ / 1000 * DEBOUNCE_MS;
endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter, debounced level and registered edge strobes.
// o_chg_nxt is the unregistered pulse term, exposed so the parent can register a shared change flag.
module debounce_bit #(
    parameter int CNT_MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw_raw,
    output logic o_db,
    output logic o_rise,
    output logic o_fall,
    output logic o_chg_nxt
);
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    logic w_accept;
    logic w_rise_nxt;
    logic w_fall_nxt;

    always_comb begin
        w_accept   = (r_s2 != r_db) && (r_cnt == CNT_LAST);
        w_rise_nxt = w_accept &  r_s2;
        w_fall_nxt = w_accept & ~r_s2;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_db   <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_s1   <= i_sw_raw;
            r_s2   <= r_s1;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            // Any return to the accepted level restarts the stability window.
            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_db  <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_db      = r_db;
    assign o_rise    = r_rise;
    assign o_fall    = r_fall;
    assign o_chg_nxt = w_rise_nxt | w_fall_nxt;
endmodule

// File: rtl/sw_debounce.sv
// Debounces WIDTH asynchronous switch inputs; latency CNT_MAX+2 cycles from a clean step.
// Emits per-bit rise/fall strobes and a registered any-change flag.
module sw_debounce
    import sw_pkg::*;
#(
    parameter int WIDTH   = 10,
    parameter int CNT_MAX = SW_CNT_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             any_change
);
    logic [WIDTH-1:0] w_chg_nxt;
    logic             r_any_change;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        debounce_bit #(
            .CNT_MAX (CNT_MAX)
        ) u_bit (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_sw_raw  (sw_raw[gi]),
            .o_db      (sw_db[gi]),
            .o_rise    (sw_rise[gi]),
            .o_fall    (sw_fall[gi]),
            .o_chg_nxt (w_chg_nxt[gi])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_any_change <= 1'b0;
        end else begin
            r_any_change <= |w_chg_nxt;
        end
    end

    assign any_change = r_any_change;
endmodule
